fetch_queue_ctrl: RTL and testbench
===================================

// Module: fetch_queue_ctrl
// PURPOSE
//  Sequencing controller for the N-way banked sequential instruction queue (banked_fifo_seq)
//  between fetch and decode. Maps a fetch bundle onto contiguous queue write lanes and hands
//  decode a contiguous prefix of read lanes. Tracks occupancy. Runs flushes by draining the
//  queue, so bank pointers stay aligned without the queue clr.
// PARAMETERS
//  N         4  lanes per cycle (power of 2, >=2); must match queue N
//  DEPTH     8  entries per bank; capacity CAP = N*DEPTH
//  HOLD_CYC  2  idle cycles after drain completes before accepting fetch again (0 allowed)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  async reset, active-low
//  fe_valid     in   [0:N-1]            fetch lane valids; must not depend on fe_ready
//  fe_ready     out  1                  whole bundle accepted this cycle
//  fq_wr_en     out  [0:N-1]            queue write enables (lane i -> queue write port i)
//  fq_wr_ok     in   [0:N-1]            queue per-lane not-full
//  fq_rd_en     out  [0:N-1]            queue read enables
//  fq_rd_ok     in   [0:N-1]            queue per-lane not-empty
//  dec_slots    in   [$clog2(N):0]      decode slots free this cycle (0..N; >N treated as N)
//  dec_valid    out  [0:N-1]            lanes of queue rd_data valid for decode
//  flush_req    in   1                  pulse: discard all queued entries
//  busy         out  1                  state != RUN
//  count        out  [$clog2(CAP+1)-1:0] occupancy
//  err_noncontig out 1                  sticky: a non-contiguous fe_valid was presented
// BEHAVIOUR
//  Reset (async): state=RUN, count=0, hold_cnt=0, err_noncontig=0.
//  - All lane outputs are combinational from state and inputs. Outputs with no inputs active
//    in RUN: fe_ready=0, fq_wr_en=0, fq_rd_en=0, dec_valid=0, busy=0.
//  States: RUN, DRAIN, HOLD.
//  Write path, RUN only:
//  - contig = fe_valid is a prefix of ones (0000, 1000, 1100, ...).
//  - fe_ready = RUN & !flush_req & |fe_valid & contig & (&(~fe_valid | fq_wr_ok)).
//  - fq_wr_en = fe_ready ? fe_valid : 0. A bundle is accepted in full or not at all.
//  - |fe_valid & !contig sets err_noncontig (sticky until reset). The bundle is never accepted.
//  Read path, RUN only:
//  - k = min(dec_slots, length of the leading-ones run of fq_rd_ok).
//  - fq_rd_en = dec_valid = first k lanes set, rest 0. Zero-latency: data is valid on the same
//    cycle (show-ahead queue).
//  Counter:
//  - count_next = count + popcount(fq_wr_en) - popcount(fq_rd_en).
//  - Never exceeds CAP and never goes below 0, given a correct queue. Simultaneous read and
//    write are both applied.
//  Flush:
//  - flush_req in RUN has priority: no write or read that cycle; next state = DRAIN.
//  - DRAIN: fe_ready=0, dec_valid=0, fq_rd_en = leading-ones run of fq_rd_ok (discard). Count
//    decrements accordingly.
//  - DRAIN -> HOLD when count_next==0, loading hold_cnt=HOLD_CYC. If HOLD_CYC==0 -> RUN instead.
//  - A flush with count==0 spends 1 cycle in DRAIN.
//  - HOLD: no lane outputs. hold_cnt decrements each cycle; at hold_cnt==1 -> RUN.
//  - flush_req in DRAIN is ignored. flush_req in HOLD reloads hold_cnt=HOLD_CYC.
//  - busy = (state != RUN).
//  Reset asserted mid-flush returns to RUN immediately. The queue must be reset by the same rst_n.
// TESTING
//  1 reset; fe_valid=1110, fq_wr_ok=1111 -> fe_ready=1, fq_wr_en=1110; next cycle count=3
//  2 count=3, fq_rd_ok=1110, dec_slots=2 -> fq_rd_en=dec_valid=1100; count 3->1.
//    Same cycle with fe_valid=1000 accepted -> count 2
//  3 fq_wr_ok=1100, fe_valid=1110 -> fe_ready=0, fq_wr_en=0000, count unchanged
//  4 fe_valid=1010 -> fe_ready=0, err_noncontig=1 next cycle and stays 1 after fe_valid=0000
//  5 count=7, flush_req with fe_valid=1111 -> no write, DRAIN.
//    DRAIN rd_en=1111 (count 3), then 1110 (count 0) -> HOLD for 2 cycles -> RUN.
//    dec_valid=0 and busy=1 throughout
//  6 rst_n low during DRAIN with count=5 -> state RUN, count=0, busy=0, err_noncontig=0
//    immediately (async)

Source files
------------

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch queue controller bundle: fetch handshake, queue lane controls, decode lanes,
// flush request and status.
//   master : the controller side (drives fe_ready, fq_wr_en, fq_rd_en, dec_valid,
//            busy, count, err_noncontig)
//   slave  : the surrounding fetch/queue/decode side (drives fe_valid, fq_wr_ok,
//            fq_rd_ok, dec_slots, flush_req)
// Lane vectors are [0:N-1]; lane 0 is the oldest slot of a bundle.
interface fetch_queue_ctrl_if #(
   parameter int N     = 4,
   parameter int DEPTH = 8
);
   localparam int CAP = N * DEPTH;
   localparam int CW  = $clog2(CAP + 1);
   localparam int SW  = $clog2(N) + 1;

   logic [0:N-1]  fe_valid;
   logic          fe_ready;
   logic [0:N-1]  fq_wr_en;
   logic [0:N-1]  fq_wr_ok;
   logic [0:N-1]  fq_rd_en;
   logic [0:N-1]  fq_rd_ok;
   logic [SW-1:0] dec_slots;
   logic [0:N-1]  dec_valid;
   logic          flush_req;
   logic          busy;
   logic [CW-1:0] count;
   logic          err_noncontig;

   modport master (
      input  fe_valid, fq_wr_ok, fq_rd_ok, dec_slots, flush_req,
      output fe_ready, fq_wr_en, fq_rd_en, dec_valid, busy, count, err_noncontig
   );

   modport slave (
      output fe_valid, fq_wr_ok, fq_rd_ok, dec_slots, flush_req,
      input  fe_ready, fq_wr_en, fq_rd_en, dec_valid, busy, count, err_noncontig
   );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Sequencing controller for the banked sequential instruction queue between fetch and
// decode. Accepts whole contiguous fetch bundles onto queue write lanes, hands decode a
// contiguous prefix of read lanes, tracks occupancy, and implements flush by draining
// the queue so the bank pointers stay aligned without a queue clear.
// Ports:
//   clk   : clock, rising edge
//   rst_n : async reset, active-low (the queue must share it)
//   io    : fetch_queue_ctrl_if master modport (lane controls and status)
//
// state | meaning
// RUN   | normal operation: accept fetch bundles, feed decode
// DRAIN | flush in progress: discard every readable entry until empty
// HOLD  | post-drain quiet period of HOLD_CYC cycles before resuming RUN
module fetch_queue_ctrl #(
   parameter int N        = 4,
   parameter int DEPTH    = 8,
   parameter int HOLD_CYC = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   fetch_queue_ctrl_if.master  io
);
   localparam int CAP = N * DEPTH;
   localparam int CW  = $clog2(CAP + 1);
   localparam int SW  = $clog2(N) + 1;
   localparam int HW  = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count_q;
   logic [HW-1:0] hold_cnt;
   logic          err_q;

   logic          contig;
   logic [SW-1:0] run_len;
   logic          run_open;
   logic [SW-1:0] slots_eff;
   logic [SW-1:0] k;
   logic [0:N-1]  k_mask;
   logic [0:N-1]  run_mask;
   logic [0:N-1]  wr_en;
   logic [0:N-1]  rd_en;
   logic          accept;
   logic [CW-1:0] count_next;

   function automatic logic [CW-1:0] popcnt(input logic [0:N-1] v);
      logic [CW-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s = s + CW'(v[i]);
      return s;
   endfunction

   always_comb begin
      contig   = 1'b1;
      run_len  = '0;
      run_open = 1'b1;
      k_mask   = '0;
      run_mask = '0;
      wr_en    = '0;
      rd_en    = '0;
      accept   = 1'b0;

      // A bundle is contiguous when no valid lane follows an invalid one.
      for (int i = 1; i < N; i++) begin
         if (io.fe_valid[i] && !io.fe_valid[i-1]) contig = 1'b0;
      end

      // Readable lanes are only usable as an unbroken run starting at lane 0.
      for (int i = 0; i < N; i++) begin
         if (run_open && io.fq_rd_ok[i]) run_len = run_len + SW'(1);
         else                            run_open = 1'b0;
      end

      slots_eff = (io.dec_slots > SW'(N)) ? SW'(N) : io.dec_slots;
      k         = (slots_eff < run_len) ? slots_eff : run_len;

      for (int i = 0; i < N; i++) begin
         k_mask[i]   = (SW'(i) < k);
         run_mask[i] = (SW'(i) < run_len);
      end

      case (state)
         RUN: begin
            if (!io.flush_req) begin
               accept = (|io.fe_valid) && contig && (&(~io.fe_valid | io.fq_wr_ok));
               wr_en  = accept ? io.fe_valid : '0;
               rd_en  = k_mask;
            end
         end
         DRAIN:   rd_en = run_mask;
         default: ;
      endcase

      count_next = count_q + popcnt(wr_en) - popcnt(rd_en);

      io.fe_ready      = accept;
      io.fq_wr_en      = wr_en;
      io.fq_rd_en      = rd_en;
      io.dec_valid     = (state == RUN) ? rd_en : '0;
      io.busy          = (state != RUN);
      io.count         = count_q;
      io.err_noncontig = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         count_q  <= '0;
         hold_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q <= count_next;
         if (state == RUN && (|io.fe_valid) && !contig) err_q <= 1'b1;
         case (state)
            RUN: begin
               if (io.flush_req) state <= DRAIN;
            end
            DRAIN: begin
               if (count_next == '0) begin
                  hold_cnt <= HW'(HOLD_CYC);
                  state    <= (HOLD_CYC == 0) ? RUN : HOLD;
               end
            end
            HOLD: begin
               // A flush during the quiet period restarts it; the queue is already empty.
               if (io.flush_req) begin
                  hold_cnt <= HW'(HOLD_CYC);
               end else if (hold_cnt == HW'(1)) begin
                  hold_cnt <= '0;
                  state    <= RUN;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
module tb_fetch_queue_ctrl;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fetch_queue_ctrl_if #(.N(4), .DEPTH(8)) qif ();

   fetch_queue_ctrl #(.N(4), .DEPTH(8), .HOLD_CYC(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (qif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      qif.fe_valid  = 4'b0000;
      qif.fq_wr_ok  = 4'b0000;
      qif.fq_rd_ok  = 4'b0000;
      qif.dec_slots = 3'd0;
      qif.flush_req = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_in();
      #3;
      chk("rst_busy",     32'(qif.busy),          0);
      chk("rst_count",    32'(qif.count),         0);
      chk("rst_err",      32'(qif.err_noncontig), 0);
      chk("rst_fe_ready", 32'(qif.fe_ready),      0);
      chk("rst_wr_en",    32'(qif.fq_wr_en),      0);
      chk("rst_rd_en",    32'(qif.fq_rd_en),      0);
      chk("rst_dec",      32'(qif.dec_valid),     0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // empty flush: one DRAIN cycle, HOLD, flush in HOLD restarts the quiet period
      qif.flush_req = 1'b1;
      tick();
      qif.flush_req = 1'b0;
      chk("ef_drain_busy", 32'(qif.busy), 1);
      tick();
      chk("ef_hold1_busy", 32'(qif.busy), 1);
      tick();
      chk("ef_hold2_busy", 32'(qif.busy), 1);
      qif.flush_req = 1'b1;
      tick();
      qif.flush_req = 1'b0;
      chk("ef_reload_busy", 32'(qif.busy), 1);
      tick();
      chk("ef_reload2_busy", 32'(qif.busy), 1);
      tick();
      chk("ef_run_busy", 32'(qif.busy), 0);

      // 1: contiguous 3-lane bundle accepted
      qif.fe_valid = 4'b1110;
      qif.fq_wr_ok = 4'b1111;
      #1;
      chk("t1_fe_ready", 32'(qif.fe_ready), 1);
      chk("t1_wr_en",    32'(qif.fq_wr_en), 32'(4'b1110));
      chk("t1_rd_en",    32'(qif.fq_rd_en), 0);
      tick();
      qif.fe_valid = 4'b0000;
      chk("t1_count", 32'(qif.count), 3);

      // read prefix limits: slots > N clamps to N, gap in rd_ok cuts the run
      qif.fq_rd_ok  = 4'b1111;
      qif.dec_slots = 3'd7;
      #1;
      chk("clamp_dec", 32'(qif.dec_valid), 32'(4'b1111));
      qif.fq_rd_ok  = 4'b1011;
      qif.dec_slots = 3'd4;
      #1;
      chk("gap_rd_en", 32'(qif.fq_rd_en), 32'(4'b1000));

      // 2: read 2 of 3 while writing 1
      qif.fq_rd_ok  = 4'b1110;
      qif.dec_slots = 3'd2;
      qif.fe_valid  = 4'b1000;
      #1;
      chk("t2_rd_en", 32'(qif.fq_rd_en),  32'(4'b1100));
      chk("t2_dec",   32'(qif.dec_valid), 32'(4'b1100));
      chk("t2_wr_en", 32'(qif.fq_wr_en),  32'(4'b1000));
      tick();
      qif.fe_valid  = 4'b0000;
      qif.fq_rd_ok  = 4'b0000;
      qif.dec_slots = 3'd0;
      chk("t2_count", 32'(qif.count), 2);

      // 3: one lane not writable -> whole bundle refused
      qif.fq_wr_ok = 4'b1100;
      qif.fe_valid = 4'b1110;
      #1;
      chk("t3_fe_ready", 32'(qif.fe_ready), 0);
      chk("t3_wr_en",    32'(qif.fq_wr_en), 0);
      tick();
      chk("t3_count", 32'(qif.count), 2);

      // 4: non-contiguous bundle refused, sticky error
      qif.fq_wr_ok = 4'b1111;
      qif.fe_valid = 4'b1010;
      #1;
      chk("t4_fe_ready", 32'(qif.fe_ready),      0);
      chk("t4_wr_en",    32'(qif.fq_wr_en),      0);
      chk("t4_err_pre",  32'(qif.err_noncontig), 0);
      tick();
      chk("t4_err", 32'(qif.err_noncontig), 1);
      qif.fe_valid = 4'b0000;
      tick();
      chk("t4_err_sticky", 32'(qif.err_noncontig), 1);
      chk("t4_count",      32'(qif.count),         2);

      // fill to 7
      qif.fe_valid = 4'b1111;
      tick();
      chk("fill_count6", 32'(qif.count), 6);
      qif.fe_valid = 4'b1000;
      tick();
      chk("fill_count7", 32'(qif.count), 7);

      // 5: flush has priority over a valid bundle and readable lanes
      qif.fe_valid  = 4'b1111;
      qif.fq_rd_ok  = 4'b1111;
      qif.dec_slots = 3'd4;
      qif.flush_req = 1'b1;
      #1;
      chk("t5_fe_ready", 32'(qif.fe_ready),  0);
      chk("t5_wr_en",    32'(qif.fq_wr_en),  0);
      chk("t5_rd_en",    32'(qif.fq_rd_en),  0);
      chk("t5_dec",      32'(qif.dec_valid), 0);
      tick();
      qif.flush_req = 1'b0;
      chk("t5_busy_d",   32'(qif.busy),      1);
      chk("t5_count7",   32'(qif.count),     7);
      chk("t5_d1_rd_en", 32'(qif.fq_rd_en),  32'(4'b1111));
      chk("t5_d1_dec",   32'(qif.dec_valid), 0);
      chk("t5_d1_ready", 32'(qif.fe_ready),  0);
      tick();
      chk("t5_count3", 32'(qif.count), 3);
      qif.fq_rd_ok = 4'b1110;
      #1;
      chk("t5_d2_rd_en", 32'(qif.fq_rd_en),  32'(4'b1110));
      chk("t5_d2_dec",   32'(qif.dec_valid), 0);
      tick();
      chk("t5_count0",   32'(qif.count),     0);
      chk("t5_h1_busy",  32'(qif.busy),      1);
      chk("t5_h1_rd_en", 32'(qif.fq_rd_en),  0);
      chk("t5_h1_ready", 32'(qif.fe_ready),  0);
      chk("t5_h1_dec",   32'(qif.dec_valid), 0);
      tick();
      chk("t5_h2_busy", 32'(qif.busy), 1);
      tick();
      qif.fq_rd_ok = 4'b0000;
      #1;
      chk("t5_run_busy",  32'(qif.busy),     0);
      chk("t5_run_ready", 32'(qif.fe_ready), 1);

      // 6: async reset in DRAIN with count=5
      tick();
      chk("t6_count4", 32'(qif.count), 4);
      qif.fe_valid = 4'b1000;
      tick();
      qif.fe_valid  = 4'b0000;
      qif.flush_req = 1'b1;
      tick();
      qif.flush_req = 1'b0;
      tick();
      chk("t6_busy_d", 32'(qif.busy),  1);
      chk("t6_count5", 32'(qif.count), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_busy",  32'(qif.busy),          0);
      chk("t6_count", 32'(qif.count),         0);
      chk("t6_err",   32'(qif.err_noncontig), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t6_post_busy", 32'(qif.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
